// File: rtl/camera_pkg.sv
// camera_pkg
//   Shared definitions for the camera sensor emulator: FSM state encoding,
//   test-pattern codes, Bayer mosaic sample values and the LFSR seed/taps.
package camera_pkg;

  // Frame sequencer states. Each state names what the outputs show this cycle.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_V_FRONT = 3'd1,
    ST_LINE    = 3'd2,
    ST_H_BLANK = 3'd3,
    ST_V_BACK  = 3'd4,
    ST_F_GAP   = 3'd5
  } state_t;

  // Test-pattern selector codes as seen on in_pattern.
  typedef enum logic [1:0] {
    PAT_HRAMP  = 2'd0,
    PAT_VRAMP  = 2'd1,
    PAT_BAYER  = 2'd2,
    PAT_LFSR   = 2'd3
  } pattern_t;

  // Bayer mosaic sample values (G on the diagonal, R on even rows, B on odd rows).
  localparam logic [7:0] BAYER_G = 8'h10;
  localparam logic [7:0] BAYER_R = 8'hF0;
  localparam logic [7:0] BAYER_B = 8'h80;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11. The register shifts right and
  // the new bit enters at [15]; taps 16,14,13,11 map onto bits 0,2,3,5.
  localparam logic [15:0] LFSR_SEED     = 16'hACE1;
  localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

endpackage

// File: rtl/lfsr16.sv
// lfsr16
//   16-bit Fibonacci LFSR used as the pseudo-random pixel source.
//   Ports:
//     clock   - rising-edge clock
//     reset   - synchronous active-high reset, loads the seed
//     load    - synchronous reseed (frame start), wins over advance
//     advance - step the sequence by one
//     value   - current register contents
module lfsr16
  import camera_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        advance,
  output logic [15:0] value
);

  logic w_feedback;

  assign w_feedback = ^(value & LFSR_TAP_MASK);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset || load) begin
      value <= LFSR_SEED;
    end else if (advance) begin
      value <= {w_feedback, value[15:1]};
    end
  end

endmodule

// File: rtl/camera_sensor_emulator.sv
// camera_sensor_emulator
//   Generates parallel-sensor style FVAL/LVAL/DATA timing with selectable
//   test patterns, for one frame on request or continuously.
//   Ports:
//     clock, reset       - rising-edge clock, synchronous active-high reset
//     in_width/height    - image W/H; line is 2*W pixels, frame is 2*H lines
//     in_pattern         - 0 h-ramp, 1 v-ramp, 2 Bayer checker, 3 LFSR
//     in_start           - single-cycle frame request (ignored while busy)
//     in_continuous      - keep producing frames while high
//     out_frame_valid    - FVAL
//     out_line_valid     - LVAL
//     out_data           - pixel data, zero outside LVAL
//     out_busy           - high from accepted start until back in IDLE
//     out_frame_done     - one-cycle pulse on the cycle FVAL falls
module camera_sensor_emulator
  import camera_pkg::*;
#(
  parameter int N       = 8,
  parameter int V_FRONT = 4,
  parameter int H_BLANK = 8,
  parameter int V_BACK  = 4,
  parameter int F_GAP   = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [11:0]  in_width,
  input  logic [11:0]  in_height,
  input  logic [1:0]   in_pattern,
  input  logic         in_start,
  input  logic         in_continuous,
  output logic         out_frame_valid,
  output logic         out_line_valid,
  output logic [N-1:0] out_data,
  output logic         out_busy,
  output logic         out_frame_done
);

  state_t        r_state;
  pattern_t      r_pattern;
  logic [11:0]   r_len;      // 2*W pixels per line
  logic [11:0]   r_lines;    // 2*H lines per frame
  logic [11:0]   r_x;
  logic [11:0]   r_y;
  logic [15:0]   r_cnt;      // shared blanking-interval counter
  logic          r_frame_valid;
  logic          r_line_valid;
  logic [N-1:0]  r_data;
  logic          r_busy;
  logic          r_frame_done;

  logic          w_dims_ok;
  logic          w_vf_end;
  logic          w_hb_end;
  logic          w_vb_end;
  logic          w_fg_end;
  logic          w_line_last_px;
  logic          w_load;
  logic          w_advance;
  logic [11:0]   w_x_next;
  logic [N-1:0]  w_pix_next;
  logic [15:0]   w_lfsr;
  logic          w_unused_msbs;

  // Only the low 11 bits of each dimension are meaningful.
  assign w_unused_msbs = in_width[11] ^ in_height[11];

  assign w_dims_ok      = (in_width[10:0] != 11'd0) && (in_height[10:0] != 11'd0);
  assign w_vf_end       = (r_cnt == 16'(V_FRONT - 1));
  assign w_hb_end       = (r_cnt == 16'(H_BLANK - 1));
  assign w_vb_end       = (r_cnt == 16'(V_BACK - 1));
  assign w_fg_end       = (r_cnt == 16'(F_GAP - 1));
  assign w_line_last_px = (r_x == r_len - 12'd1);

  // Reseed at every frame start: accepted start from IDLE or continuous restart.
  assign w_load = ((r_state == ST_IDLE)  && in_start && w_dims_ok) ||
                  ((r_state == ST_F_GAP) && w_fg_end && w_dims_ok);

  // Step once for every edge that puts a pixel on the bus.
  assign w_advance = ((r_state == ST_V_FRONT) && w_vf_end) ||
                     ((r_state == ST_H_BLANK) && w_hb_end) ||
                     ((r_state == ST_LINE)    && !w_line_last_px);

  function automatic logic [N-1:0] pixel(input pattern_t p, input logic [11:0] x,
                                         input logic [11:0] y, input logic [15:0] l);
    logic [N-1:0] v;
    v = '0;
    unique case (p)
      PAT_HRAMP: v = N'(x);
      PAT_VRAMP: v = N'(y);
      PAT_BAYER: begin
        if (x[0] == y[0])  v = N'(BAYER_G);
        else if (!y[0])    v = N'(BAYER_R);
        else               v = N'(BAYER_B);
      end
      PAT_LFSR:  v = N'(l);
      default:   v = '0;
    endcase
    return v;
  endfunction

  // NOTE: every signal written in always_comb gets a value on every path
  // (defaults first) so no latch is inferred.
  always_comb begin
    w_x_next = 12'd0;
    if (r_state == ST_LINE) begin
      w_x_next = r_x + 12'd1;
    end
    w_pix_next = pixel(r_pattern, w_x_next, r_y, w_lfsr);
  end

  lfsr16 u_lfsr (
    .clock   (clock),
    .reset   (reset),
    .load    (w_load),
    .advance (w_advance),
    .value   (w_lfsr)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_pattern     <= PAT_HRAMP;
      r_len         <= 12'd0;
      r_lines       <= 12'd0;
      r_x           <= 12'd0;
      r_y           <= 12'd0;
      r_cnt         <= 16'd0;
      r_frame_valid <= 1'b0;
      r_line_valid  <= 1'b0;
      r_data        <= '0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (in_start && w_dims_ok) begin
            r_len         <= {in_width[10:0], 1'b0};
            r_lines       <= {in_height[10:0], 1'b0};
            r_pattern     <= pattern_t'(in_pattern);
            r_x           <= 12'd0;
            r_y           <= 12'd0;
            r_cnt         <= 16'd0;
            r_frame_valid <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= ST_V_FRONT;
          end
        end

        ST_V_FRONT: begin
          if (w_vf_end) begin
            r_line_valid <= 1'b1;
            r_data       <= w_pix_next;
            r_state      <= ST_LINE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        ST_LINE: begin
          if (w_line_last_px) begin
            r_line_valid <= 1'b0;
            r_data       <= '0;
            r_x          <= 12'd0;
            r_cnt        <= 16'd0;
            if (r_y == r_lines - 12'd1) begin
              r_state <= ST_V_BACK;
            end else begin
              r_y     <= r_y + 12'd1;
              r_state <= ST_H_BLANK;
            end
          end else begin
            r_x    <= w_x_next;
            r_data <= w_pix_next;
          end
        end

        ST_H_BLANK: begin
          if (w_hb_end) begin
            r_line_valid <= 1'b1;
            r_data       <= w_pix_next;
            r_state      <= ST_LINE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        ST_V_BACK: begin
          if (w_vb_end) begin
            r_frame_valid <= 1'b0;
            r_frame_done  <= 1'b1;
            r_cnt         <= 16'd0;
            if (in_continuous) begin
              r_state <= ST_F_GAP;
            end else begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        ST_F_GAP: begin
          if (w_fg_end) begin
            // A zero dimension at relatch time cannot form a frame; stop instead.
            if (w_dims_ok) begin
              r_len         <= {in_width[10:0], 1'b0};
              r_lines       <= {in_height[10:0], 1'b0};
              r_pattern     <= pattern_t'(in_pattern);
              r_x           <= 12'd0;
              r_y           <= 12'd0;
              r_cnt         <= 16'd0;
              r_frame_valid <= 1'b1;
              r_state       <= ST_V_FRONT;
            end else begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_frame_valid = r_frame_valid;
  assign out_line_valid  = r_line_valid;
  assign out_data        = r_data;
  assign out_busy        = r_busy;
  assign out_frame_done  = r_frame_done;

endmodule

// File: tb/tb_camera_sensor_emulator.sv
// tb_camera_sensor_emulator
//   Randomized and directed stimulus for camera_sensor_emulator. Expected
//   per-cycle traces are built from the frame timing rules (interval lengths,
//   pixel formulas) and compared against the outputs one cycle at a time.
module tb_camera_sensor_emulator;

  localparam int N  = 8;
  localparam int VF = 4;
  localparam int HB = 8;
  localparam int VB = 4;
  localparam int FG = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [11:0]  in_width = '0;
  logic [11:0]  in_height = '0;
  logic [1:0]   in_pattern = '0;
  logic         in_start = 1'b0;
  logic         in_continuous = 1'b0;
  logic         out_frame_valid;
  logic         out_line_valid;
  logic [N-1:0] out_data;
  logic         out_busy;
  logic         out_frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected trace entries: {fv, lv, busy, done, data[7:0]}
  logic [11:0] exp_q[$];

  camera_sensor_emulator #(
    .N(N), .V_FRONT(VF), .H_BLANK(HB), .V_BACK(VB), .F_GAP(FG)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .in_width       (in_width),
    .in_height      (in_height),
    .in_pattern     (in_pattern),
    .in_start       (in_start),
    .in_continuous  (in_continuous),
    .out_frame_valid(out_frame_valid),
    .out_line_valid (out_line_valid),
    .out_data       (out_data),
    .out_busy       (out_busy),
    .out_frame_done (out_frame_done)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, expected completion before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [11:0] obs();
    return {out_frame_valid, out_line_valid, out_busy, out_frame_done, out_data};
  endfunction

  function automatic int lfsr_step(input int l);
    int b;
    b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
    return ((l >> 1) | (b << 15)) & 16'hFFFF;
  endfunction

  function automatic logic [7:0] pix(input int pat, input int x, input int y, input int lf);
    case (pat)
      0: return 8'(x);
      1: return 8'(y);
      2: begin
        if ((x % 2) == (y % 2)) return 8'h10;
        else if ((y % 2) == 0)  return 8'hF0;
        else                    return 8'h80;
      end
      default: return 8'(lf);
    endcase
  endfunction

  function automatic void push(input bit fv, input bit lv, input bit busy,
                               input bit done, input logic [7:0] d);
    exp_q.push_back({fv, lv, busy, done, d});
  endfunction

  // Builds the trace of nf back-to-back frames starting on the cycle after the
  // start edge, followed by four idle cycles. last_start is the index of the
  // first V_FRONT cycle of the final frame.
  task automatic build(input int w, input int h, input int pat, input int nf,
                       output int last_start);
    int lf;
    last_start = 0;
    for (int f = 0; f < nf; f++) begin
      lf = 16'hACE1;
      if (f == nf - 1) last_start = exp_q.size();
      repeat (VF) push(1, 0, 1, 0, 8'h00);
      for (int y = 0; y < 2 * h; y++) begin
        for (int x = 0; x < 2 * w; x++) begin
          push(1, 1, 1, 0, pix(pat, x, y, lf));
          lf = lfsr_step(lf);
        end
        if (y < 2 * h - 1) repeat (HB) push(1, 0, 1, 0, 8'h00);
      end
      repeat (VB) push(1, 0, 1, 0, 8'h00);
      push(0, 0, f != nf - 1, 1, 8'h00);
      if (f != nf - 1) repeat (FG - 1) push(0, 0, 1, 0, 8'h00);
    end
    repeat (4) push(0, 0, 0, 0, 8'h00);
  endtask

  // Issues a start and compares every following cycle against the built trace.
  // With noise set, start is re-pulsed and the size/pattern inputs scrambled
  // while the frame is in progress; the frame must not change.
  task automatic run_frames(input int w, input int h, input int pat, input int nf,
                            input bit noise, input string name);
    int last_start;
    int gap;
    int sz;
    exp_q.delete();
    build(w, h, pat, nf, last_start);
    sz            = exp_q.size();
    gap           = 0;
    in_width      = 12'(w);
    in_height     = 12'(h);
    in_pattern    = 2'(pat);
    in_continuous = (nf > 1);
    in_start      = 1'b1;
    for (int i = 0; i < sz; i++) begin
      if (i > 0) begin
        in_continuous = (i < last_start);
        if (noise && i < sz - 4) begin
          in_start   = 1'($urandom);
          in_width   = 12'($urandom);
          in_height  = 12'($urandom);
          in_pattern = 2'($urandom);
        end else begin
          in_start   = 1'b0;
          in_width   = 12'(w);
          in_height  = 12'(h);
          in_pattern = 2'(pat);
        end
      end
      tick();
      check($sformatf("%s[%0d]", name, i), 32'(obs()), 32'(exp_q[i]));
      if (out_busy && !out_frame_valid) gap++;
    end
    if (nf > 1) check({name, "_gap"}, gap, FG * (nf - 1));
    in_start      = 1'b0;
    in_continuous = 1'b0;
  endtask

  initial begin
    int lv_seen;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    check("reset_outputs", 32'(obs()), 32'h0);
    reset = 1'b0;
    tick();
    check("post_reset_idle", 32'(obs()), 32'h0);

    // Horizontal ramp, W=2 H=1
    run_frames(2, 1, 0, 1, 1'b0, "hramp");

    // Bayer checker, W=3 H=2
    run_frames(3, 2, 2, 1, 1'b0, "bayer");

    // Vertical ramp
    run_frames(2, 3, 1, 1, 1'b0, "vramp");

    // Zero dimensions are ignored
    in_width  = 12'd0;
    in_height = 12'd5;
    in_start  = 1'b1;
    tick();
    in_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("zero_w[%0d]", i), 32'(obs()), 32'h0);
    end
    in_width  = 12'd3;
    in_height = 12'd0;
    in_start  = 1'b1;
    tick();
    in_start = 1'b0;
    check("zero_h", 32'(obs()), 32'h0);
    // Bit 11 is outside the used range: 12'h800 is still a zero width
    in_width  = 12'h800;
    in_height = 12'd1;
    in_start  = 1'b1;
    tick();
    in_start = 1'b0;
    check("zero_w_msb", 32'(obs()), 32'h0);

    // Start and inputs toggled during the frame leave it unchanged
    run_frames(2, 2, 0, 1, 1'b1, "restart_ignored");

    // LFSR pattern, two continuous frames
    run_frames(4, 1, 3, 2, 1'b0, "lfsr_cont");

    // Randomized frames
    for (int t = 0; t < 8; t++) begin
      int rw, rh, rp, rn;
      rw = $urandom_range(1, 4);
      rh = $urandom_range(1, 2);
      rp = $urandom_range(0, 3);
      rn = $urandom_range(1, 2);
      run_frames(rw, rh, rp, rn, (rn == 1) && ($urandom_range(0, 1) == 1),
                 $sformatf("rand%0d", t));
    end

    // Mid-frame reset on the third line_valid-high cycle
    in_width   = 12'd3;
    in_height  = 12'd2;
    in_pattern = 2'd0;
    in_start   = 1'b1;
    tick();
    in_start = 1'b0;
    lv_seen  = 0;
    for (int k = 0; k < 200 && lv_seen < 3; k++) begin
      tick();
      if (out_line_valid) lv_seen++;
    end
    check("lv_reach", lv_seen, 3);
    reset = 1'b1;
    tick();
    check("midframe_reset", 32'(obs()), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      check($sformatf("after_reset[%0d]", i), 32'(obs()), 32'h0);
    end
    run_frames(3, 2, 3, 1, 1'b0, "post_reset_frame");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
